mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and grant-owner id.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  function automatic arb_state_e grant_state(input owner_e owner);
    return (owner == OWNER_D) ? ST_GNT_D : ST_GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selector: a lone requester wins; on conflict the
// requester that did not hold the previous grant wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_ic_req,
  input  logic   i_dc_req,
  input  owner_e i_last_grant,
  output logic   o_valid,
  output owner_e o_owner
);

  always_comb begin
    o_valid = i_ic_req | i_dc_req;
    o_owner = OWNER_D;
    if (i_ic_req && !i_dc_req) begin
      o_owner = OWNER_I;
    end else if (i_ic_req && i_dc_req && (i_last_grant == OWNER_D)) begin
      o_owner = OWNER_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data caches onto one shared memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating conflict resolution; otherwise D wins conflicts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy
);

  // Handshake: a requester raises read/write and holds it with stable address
  // and data until its *_mem_ready pulse, then drops it the following cycle.
  // The memory completes the granted access by pulsing mem_ready for one cycle.
  // The bubble cycle after every completion keeps a stale request from being re-granted.

  arb_state_e r_state;
  owner_e     w_last_grant;
  owner_e     w_pick_owner;
  logic       w_pick_valid;
  logic       w_ic_req;
  logic       w_dc_req;

  assign w_ic_req = ic_mem_read;
  assign w_dc_req = dc_mem_read | dc_mem_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e r_last_grant;
  assign w_last_grant = r_last_grant;
`else
  // Presenting I as the last owner makes the picker always favour D.
  assign w_last_grant = OWNER_I;
`endif

  mem_arb_pick u_pick (
    .i_ic_req     (w_ic_req),
    .i_dc_req     (w_dc_req),
    .i_last_grant (w_last_grant),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state <= ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant <= OWNER_D;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state <= grant_state(w_pick_owner);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_pick_owner;
`endif
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (mem_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_mem_ready = 1'b0;
    dc_mem_ready = 1'b0;
    case (r_state)
      ST_GNT_I: begin
        mem_read     = ic_mem_read;
        mem_addr     = ic_mem_addr;
        ic_mem_ready = mem_ready;
      end
      ST_GNT_D: begin
        mem_read     = dc_mem_read;
        mem_write    = dc_mem_write;
        mem_addr     = dc_mem_addr;
        mem_wdata    = dc_mem_wdata;
        dc_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;
  assign arb_busy     = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal cases, then randomized traffic
// checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              proc_reset_n;
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [DATA_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;
  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [DATA_W-1:0] dc_mem_wdata;
  logic [DATA_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              arb_busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .arb_busy     (arb_busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: who owns the memory ----------------
  // owner: 0 = nobody, 1 = instruction cache, 2 = data cache
  int m_owner;
  bit m_last_d;

  always @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      m_owner  = 0;
      m_last_d = 1'b1;
    end else if (m_owner == 0) begin
      bit want_i, want_d;
      want_i = ic_mem_read;
      want_d = dc_mem_read | dc_mem_write;
      if (want_i && want_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_owner = m_last_d ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (want_i) begin
        m_owner = 1;
      end else if (want_d) begin
        m_owner = 2;
      end
      if (m_owner != 0) m_last_d = (m_owner == 2);
    end else if (mem_ready) begin
      m_owner = 0;
    end
  end

  // ---------------- per-cycle compare + sampling for the drivers ----------------
  bit s_busy, s_ic_rdy, s_dc_rdy;
  int ic_pulses, dc_pulses;

  always @(negedge clk) begin
    chk("busy",      arb_busy,     m_owner != 0);
    chk("mem_read",  mem_read,     m_owner == 1 ? ic_mem_read : (m_owner == 2 ? dc_mem_read : 1'b0));
    chk("mem_write", mem_write,    m_owner == 2 ? dc_mem_write : 1'b0);
    chk("mem_addr",  mem_addr,     m_owner == 1 ? ic_mem_addr : (m_owner == 2 ? dc_mem_addr : '0));
    chk("mem_wdata", mem_wdata,    m_owner == 2 ? dc_mem_wdata : '0);
    chk("ic_ready",  ic_mem_ready, (m_owner == 1) && mem_ready);
    chk("dc_ready",  dc_mem_ready, (m_owner == 2) && mem_ready);
    chk("ic_rdata",  ic_mem_rdata, mem_rdata);
    chk("dc_rdata",  dc_mem_rdata, mem_rdata);
    s_busy   = mem_read | mem_write;
    s_ic_rdy = ic_mem_ready;
    s_dc_rdy = dc_mem_ready;
    if (ic_mem_ready) ic_pulses++;
    if (dc_mem_ready) dc_pulses++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int pulses_before;
    logic [ADDR_W-1:0] exp_addr;
    proc_reset_n = 1'b0;
    ic_mem_read  = 1'b0;
    ic_mem_addr  = '0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    ic_pulses    = 0;
    dc_pulses    = 0;
    repeat (3) tick();
    chk("rst_busy",  arb_busy, 1'b0);
    chk("rst_read",  mem_read, 1'b0);
    chk("rst_addr",  mem_addr, 28'h0);
    chk("rst_ic_rd", ic_mem_ready, 1'b0);
    chk("rst_dc_rd", dc_mem_ready, 1'b0);
    proc_reset_n = 1'b1;
    tick();

    // IC read alone, ready after 3 cycles
    pulses_before = ic_pulses;
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h0000010;
    tick();
    chk("ic_busy", arb_busy, 1'b1);
    chk("ic_mread", mem_read, 1'b1);
    chk("ic_maddr", mem_addr, 28'h0000010);
    chk("ic_mwrite", mem_write, 1'b0);
    tick(); tick();
    mem_ready = 1'b1;
    mem_rdata = 128'h0123456789abcdef_fedcba9876543210;
    #1;
    chk("ic_ready1", ic_mem_ready, 1'b1);
    chk("ic_dcrdy0", dc_mem_ready, 1'b0);
    chk("ic_rdata", ic_mem_rdata, 128'h0123456789abcdef_fedcba9876543210);
    tick();
    mem_ready   = 1'b0;
    ic_mem_read = 1'b0;
    #1;
    chk("ic_bubble", arb_busy, 1'b0);
    tick();
    chk("ic_pulses", ic_pulses - pulses_before, 1);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Both held for four transactions after an I grant: D,I,D,I
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000050;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h0000060;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_addr = (k % 2 == 0) ? 28'h0000060 : 28'h0000050;
      chk("rr_order", mem_addr, exp_addr);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (k == 3) begin
        ic_mem_read = 1'b0;
        dc_mem_read = 1'b0;
      end
    end
    tick();
`endif

    // DC write alone
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h0000020;
    dc_mem_wdata = {16{8'hA5}};
    tick();
    chk("dw_mwrite", mem_write, 1'b1);
    chk("dw_mread", mem_read, 1'b0);
    chk("dw_wdata", mem_wdata, {16{8'hA5}});
    mem_ready = 1'b1;
    #1;
    chk("dw_ready", dc_mem_ready, 1'b1);
    chk("dw_icrdy0", ic_mem_ready, 1'b0);
    tick();
    mem_ready    = 1'b0;
    dc_mem_write = 1'b0;
    tick();

    // Simultaneous requests: D first (fixed) / I first (round robin, last was D)
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000030;
    dc_mem_read = 1'b1; dc_mem_addr = 28'h0000040;
    tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("cf_first", mem_addr, 28'h0000030);
    mem_ready = 1'b1; #1;
    chk("cf_rdy1", ic_mem_ready, 1'b1);
    chk("cf_nrdy1", dc_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0; ic_mem_read = 1'b0; #1;
    chk("cf_bubble", arb_busy, 1'b0);
    tick();
    chk("cf_second", mem_addr, 28'h0000040);
    mem_ready = 1'b1; #1;
    chk("cf_rdy2", dc_mem_ready, 1'b1);
    chk("cf_nrdy2", ic_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0; dc_mem_read = 1'b0;
`else
    chk("cf_first", mem_addr, 28'h0000040);
    mem_ready = 1'b1; #1;
    chk("cf_rdy1", dc_mem_ready, 1'b1);
    chk("cf_nrdy1", ic_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0; dc_mem_read = 1'b0; #1;
    chk("cf_bubble", arb_busy, 1'b0);
    tick();
    chk("cf_second", mem_addr, 28'h0000030);
    mem_ready = 1'b1; #1;
    chk("cf_rdy2", ic_mem_ready, 1'b1);
    chk("cf_nrdy2", dc_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0; ic_mem_read = 1'b0;
`endif
    tick();

    // Stray mem_ready in IDLE
    mem_ready = 1'b1;
    tick();
    chk("stray_busy", arb_busy, 1'b0);
    chk("stray_ic", ic_mem_ready, 1'b0);
    chk("stray_dc", dc_mem_ready, 1'b0);
    mem_ready = 1'b0;
    tick();

    // Reset during GNT_I, then re-grant of the still-pending request
    ic_mem_read = 1'b1; ic_mem_addr = 28'h0000070;
    tick();
    chk("rs_busy1", arb_busy, 1'b1);
    #2 proc_reset_n = 1'b0;
    #1;
    chk("rs_busy0", arb_busy, 1'b0);
    chk("rs_read0", mem_read, 1'b0);
    tick();
    proc_reset_n = 1'b1;
    tick();
    chk("rs_regrant", arb_busy, 1'b1);
    chk("rs_addr", mem_addr, 28'h0000070);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; ic_mem_read = 1'b0;
    tick();

    // Randomized traffic: protocol-following requesters and a memory with random latency
    lat = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (!proc_reset_n) begin
        proc_reset_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        proc_reset_n = 1'b0;
      end
      if (mem_ready) begin
        mem_ready = 1'b0;
        lat = -1;
      end else if (s_busy) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) mem_ready = 1'b1;
        else lat--;
      end else begin
        mem_ready = ($urandom_range(0, 15) == 0);
      end
      if (ic_mem_read && s_ic_rdy) begin
        ic_mem_read = 1'b0;
      end else if (!ic_mem_read && $urandom_range(0, 2) == 0) begin
        ic_mem_read = 1'b1;
        ic_mem_addr = ADDR_W'($urandom);
      end
      if ((dc_mem_read || dc_mem_write) && s_dc_rdy) begin
        dc_mem_read  = 1'b0;
        dc_mem_write = 1'b0;
      end else if (!(dc_mem_read || dc_mem_write) && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) dc_mem_read = 1'b1;
        else dc_mem_write = 1'b1;
        dc_mem_addr  = ADDR_W'($urandom);
        dc_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    proc_reset_n = 1'b1;
    ic_mem_read  = 1'b0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    mem_ready    = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
